// File: rtl/sr_cmd_gen_pkg.sv
// sr_cmd_pkg: shared debounce state encoding and synchronizer depth for sr_cmd_gen.
package sr_cmd_pkg;
    typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} deb_state_t;
    localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/sr_cmd_gen_if.sv
// sr_cmd_gen_if: button inputs and latch command/shadow outputs of sr_cmd_gen.
// SR_CMD_GEN_CONFLICT_FLAG_EN adds the conflict flag.
interface sr_cmd_gen_if;
    logic btn_set;
    logic btn_rst;
    logic S;
    logic R;
    logic Q;
    logic Qbar;
`ifdef SR_CMD_GEN_CONFLICT_FLAG_EN
    logic conflict;
    modport master (output btn_set, btn_rst, input S, R, Q, Qbar, conflict);
    modport slave (input btn_set, btn_rst, output S, R, Q, Qbar, conflict);
`else
    modport master (output btn_set, btn_rst, input S, R, Q, Qbar);
    modport slave (input btn_set, btn_rst, output S, R, Q, Qbar);
`endif
endinterface

// File: rtl/sr_cmd_gen_btn_debounce.sv
// btn_debounce: synchronizes a raw button and emits one press_evt per accepted press.
// SR_CMD_GEN_CONFLICT_FLAG_EN adds the pressed status output.
module btn_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
`ifdef SR_CMD_GEN_CONFLICT_FLAG_EN
    output logic pressed,
`endif
    output logic press_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    deb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic evt_q, evt_d;
    logic in_s;

    assign in_s = sync_q[SYNC_DEPTH-1];
    // Saturating increment: the counter must never wrap back into range.
    assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        sync_d  = {sync_q[SYNC_DEPTH-2:0], btn};
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        case (state_q)
            IDLE: if (in_s) begin
                state_d = ARMING;
                cnt_d   = CW'(1);
            end
            ARMING: if (!in_s) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q == CMAX) begin
                state_d = PRESSED;
                cnt_d   = '0;
                evt_d   = 1'b1;
            end else cnt_d = cnt_inc;
            PRESSED: if (!in_s) begin
                state_d = RELEASING;
                cnt_d   = CW'(1);
            end
            RELEASING: if (in_s) begin
                state_d = PRESSED;
                cnt_d   = '0;
            end else if (cnt_q == CMAX) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else cnt_d = cnt_inc;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign press_evt = evt_q;
`ifdef SR_CMD_GEN_CONFLICT_FLAG_EN
    assign pressed = (state_q == PRESSED);
`endif
endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced set/reset pulse generator with reset-dominant arbitration and Q shadow.
// SR_CMD_GEN_CONFLICT_FLAG_EN adds a conflict pulse output.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    sr_cmd_gen_if.slave io
);
    logic evt_s, evt_r;
    logic s_q, s_d, r_q, r_d, q_q, q_d;

`ifdef SR_CMD_GEN_CONFLICT_FLAG_EN
    logic pr_s, pr_r, conflict_q, conflict_d;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
        .clk(clk), .rst(rst), .btn(io.btn_set), .pressed(pr_s), .press_evt(evt_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
        .clk(clk), .rst(rst), .btn(io.btn_rst), .pressed(pr_r), .press_evt(evt_r));
    // A channel that just fired is itself PRESSED, so this also covers coincident events.
    assign conflict_d = (evt_s & pr_r) | (evt_r & pr_s);
    always_ff @(posedge clk) begin
        if (rst) conflict_q <= 1'b0;
        else conflict_q <= conflict_d;
    end
    assign io.conflict = conflict_q;
`else
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
        .clk(clk), .rst(rst), .btn(io.btn_set), .press_evt(evt_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
        .clk(clk), .rst(rst), .btn(io.btn_rst), .press_evt(evt_r));
`endif

    always_comb begin
        r_d = evt_r;
        s_d = evt_s & ~evt_r;
        q_d = evt_r ? 1'b0 : (evt_s ? 1'b1 : q_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= 1'b0;
            r_q <= 1'b0;
            q_q <= 1'b0;
        end else begin
            s_q <= s_d;
            r_q <= r_d;
            q_q <= q_d;
        end
    end

    assign io.S    = s_q;
    assign io.R    = r_q;
    assign io.Q    = q_q;
    assign io.Qbar = ~q_q;
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: scoreboard bench for sr_cmd_gen against a run-length debounce model.
module tb_sr_cmd_gen;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sr_cmd_gen_if io ();

    sr_cmd_gen #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic r;
        logic conf;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic m_q = 1'b0;
    bit   h1[2], h2[2], smp[2], lvl[2], ev[2];
    int   run[2];
    bit   pend_s, pend_r, pend_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference: a button's accepted level flips once the synchronized input has
    // disagreed with it for D+1 consecutive cycles; a flip to 1 is a press.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                h1[i] = 0; h2[i] = 0; lvl[i] = 0; run[i] = 0;
            end
            pend_s = 0; pend_r = 0; pend_c = 0;
            m_q = 1'b0;
        end else begin
            if (pend_r || pend_s) begin
                sb.push_back('{cyc, pend_r, pend_c});
                m_q = !pend_r;
            end
            for (int i = 0; i < 2; i++) begin
                smp[i] = h2[i];
                h2[i]  = h1[i];
                ev[i]  = 0;
                if (smp[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        lvl[i] = smp[i];
                        run[i] = 0;
                        ev[i]  = smp[i];
                    end
                end else run[i] = 0;
            end
            h1[0] = io.btn_set;
            h1[1] = io.btn_rst;
            pend_s = ev[0];
            pend_r = ev[1];
            pend_c = (ev[0] && lvl[1] && run[1] == 0) || (ev[1] && lvl[0] && run[0] == 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("pulse_missing", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        chk("q_qbar", {io.Q, io.Qbar}, {m_q, ~m_q});
        chk("s_r_exclusive", io.S & io.R, 0);
        if (io.S || io.R) begin
            if (sb.size() == 0) chk("unexpected_pulse", {io.S, io.R}, 0);
            else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_kind", {io.S, io.R}, e.r ? 2'b01 : 2'b10);
`ifdef SR_CMD_GEN_CONFLICT_FLAG_EN
                chk("conflict", io.conflict, e.conf);
`endif
            end
        end
`ifdef SR_CMD_GEN_CONFLICT_FLAG_EN
        else chk("conflict_idle", io.conflict, 0);
`endif
    end

    task automatic seg(input bit s, input bit r, input int n);
        io.btn_set = s;
        io.btn_rst = r;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        io.btn_set = 1'b1;
        io.btn_rst = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seg(1, 1, 20);
        seg(0, 0, 20);
        seg(1, 0, 15);
        seg(0, 0, 15);
        seg(1, 1, 15);
        seg(0, 0, 15);
        for (int i = 0; i < 5; i++) begin
            seg(0, 1, 2);
            seg(0, 0, 1);
        end
        seg(0, 1, 15);
        seg(0, 0, 15);
        seg(1, 0, 12);
        seg(0, 0, 2);
        seg(1, 0, 10);
        seg(0, 0, 15);
        seg(1, 0, 12);
        seg(0, 0, 15);
        seg(0, 1, 12);
        seg(0, 0, 15);
        seg(1, 0, 3);
        rst = 1'b1;
        seg(1, 0, 1);
        rst = 1'b0;
        seg(1, 0, 15);
        seg(0, 0, 15);
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 19);
            if (k == 0) begin
                rst = 1'b1;
                seg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 2));
                rst = 1'b0;
            end else if (k < 6) begin
                repeat ($urandom_range(1, 8)) seg($urandom_range(0, 1), $urandom_range(0, 1), 1);
            end else begin
                seg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 3 * D));
            end
        end
        seg(0, 0, 4 * D);
        chk("scoreboard_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Clocked command generator that drives the set/reset inputs of the team's SR storage elements from two raw push-buttons. Each button is synchronized, debounced and edge-detected into a single-cycle `S` or `R` pulse; simultaneous requests are arbitrated so the forbidden S=R=1 input never reaches the latch. A registered shadow copy of the expected latch state (`Q`/`Qbar`) is kept for LEDs and for checking.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized cycles required to accept a press or a release (≥1).
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_set`  in  1  raw, asynchronous set button (active high).
- `btn_rst`  in  1  raw, asynchronous reset button (active high).
- `S`  out  1  one-cycle set pulse to the latch.
- `R`  out  1  one-cycle reset pulse to the latch.
- `Q`  out  1  registered expected latch state.
- `Qbar`  out  1  always `~Q`.

## Operation
- Reset values: `S=0`, `R=0`, `Q=0`, `Qbar=1`. Synchronizers cleared, channel FSMs in IDLE, counters 0.
- Per channel: 2-flop synchronizer, then FSM with states IDLE, ARMING, PRESSED, RELEASING.
  - IDLE: sync=1 → ARMING, count=1.
  - ARMING: sync=1 and count=DEBOUNCE_CYCLES → PRESSED and raise the press event; sync=1 otherwise → count+1; sync=0 → IDLE, count=0.
  - PRESSED: sync=0 → RELEASING, count=1; otherwise hold. A held button produces no further events.
  - RELEASING: sync=0 and count=DEBOUNCE_CYCLES → IDLE; sync=0 otherwise → count+1; sync=1 → PRESSED, count=0, no new event.
- Counter width `$clog2(DEBOUNCE_CYCLES+1)`. The counter saturates and never wraps.
- Arbitration is registered:
  - Set event only: `S=1` for one cycle and `Q←1`.
  - Reset event only: `R=1` for one cycle and `Q←0`.
  - Both events in the same cycle: reset dominates, so `R=1`, `S=0`, `Q←0`.
- `S` and `R` are never high in the same cycle. Pulses in consecutive cycles are allowed.
- A set pulse while `Q=1`, or a reset pulse while `Q=0`, is still emitted; `Q` is unchanged.
- `rst` asserted at any point, including mid-debounce or mid-pulse, returns the block to reset values on that edge. No pending event survives reset.

## Timing
- Latency from raw edge to pulse: raw high sampled at edge 0, sync high at edge 2, event at edge 2+DEBOUNCE_CYCLES, `S`/`R` high after edge 3+DEBOUNCE_CYCLES for exactly one cycle.
- `Q` updates on the same edge that `S`/`R` rise.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no pulse.
- Minimum spacing between two accepted presses on one channel: 2·DEBOUNCE_CYCLES+2 cycles.

## Configuration
- `SR_CMD_GEN_CONFLICT_FLAG_EN` defined:
  - Adds output `conflict` (1 bit, reset 0).
  - `conflict` pulses high for one cycle, aligned with `R`, whenever both events coincide.
  - `conflict` also pulses when one channel's event arrives while the other channel is in PRESSED.
  - Arbitration is unchanged.
- Macro undefined: no `conflict` port and no related logic. All other behaviour is identical.

## Structure
- Package `sr_cmd_pkg`:
  - enum `deb_state_t` {IDLE, ARMING, PRESSED, RELEASING}.
  - localparam for the synchronizer depth (2).
- Sub-module `btn_debounce` (synchronizer + FSM + counter, `press_evt` output), instantiated once per button. The top level holds arbitration and the `Q` register.

## Test plan
- Reset: hold `rst` for 3 cycles with both buttons high → `S=R=0`, `Q=0`, `Qbar=1` throughout; no pulse follows until after the first edge with `rst` deasserted.
- Clean press (DEBOUNCE_CYCLES=4): `btn_set` rises at edge 0 and is held → `S=1` only after edge 7, `Q=1` from edge 7, no further `S` while held.
- Bounce: `btn_rst` toggles high 2 cycles, low 1 cycle, repeated 5 times, then stays high → exactly one `R` pulse, 7 cycles after the final rise.
- Simultaneous: both buttons rise on the same edge with `Q=1` → `R=1`, `S=0`, `Q=0`; `conflict=1` on that cycle when the macro is defined.
- Release bounce: press accepted, then a 2-cycle low glitch, then high again → no second pulse; a clean release followed by a new press yields a new pulse.
- Reset mid-debounce: `btn_set` high for 3 cycles, `rst` pulsed, button kept high → pulse at 4+3 cycles after `rst` deasserts, never earlier.
